video_timing: RTL
=================

# video_timing

Pixel-clock and raster timing sequencer for the shared video output path. It divides the system clock into a pixel enable and walks horizontal and vertical counters through active, front-porch, sync and back-porch phases. It drives the blank, sync and pixel-enable inputs of the downstream video mixer, plus pixel coordinates for the pixel source. Start and stop are gated by an enable and always land on a frame boundary.

## Interface
- CLK_DIV, 4: clk cycles per pixel (≥1)
- H_ACTIVE, 320 / H_FP, 16 / H_SYNC, 32 / H_BP, 32: horizontal phase lengths in pixels; H_TOTAL = sum (400)
- V_ACTIVE, 240 / V_FP, 4 / V_SYNC, 3 / V_BP, 15: vertical phase lengths in lines; V_TOTAL = sum (262)
- HS_POL, 0 / VS_POL, 0: sync active level (0 = active-low)
- clk  in  1  system clock; one clock domain; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run request, sampled every clk
- ce_pix  out  1  one-clk pixel enable pulse
- hcount  out  9  current pixel column, 0..H_TOTAL-1
- vcount  out  9  current line, 0..V_TOTAL-1
- HBlank / VBlank  out  1  blanking flags, active-high
- HSync / VSync  out  1  sync, level per HS_POL/VS_POL
- line_start  out  1  high with ce_pix when hcount==0
- frame_start  out  1  high with ce_pix at (0,0)
- running  out  1  high while in RUN

## Operation
- Two states: IDLE, RUN.
- IDLE: divider held at 0, counters at 0, ce_pix=0, HBlank=VBlank=1, syncs inactive. enable=1 moves the block to RUN on the next clk.
- RUN: divider counts 0..CLK_DIV-1 and wraps. On each wrap, ce_pix=1 for one clk and a new pixel is presented: hcount/vcount, blanks, syncs, line_start and frame_start all update in that same cycle. They are held at all other times.
- The first pixel presented after entering RUN is (0,0), with frame_start=1.
- Per pixel, hcount increments. At hcount==H_TOTAL-1, hcount wraps to 0 and vcount increments. At vcount==V_TOTAL-1 with hcount==H_TOTAL-1, vcount also wraps to 0.
- Flags are decoded from the presented coordinates:
  - HBlank = hcount ≥ H_ACTIVE
  - HSync active for H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC
  - VBlank = vcount ≥ V_ACTIVE
  - VSync active for V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC
  - Vertical flags therefore change only on line_start pixels.
- Stop: if enable=0 at the wrap that would present (0,0), the block goes to IDLE instead. No ce_pix is issued, and outputs take IDLE values in the next cycle. Deasserting enable mid-frame always finishes the current frame. Reasserting enable before that wrap cancels the stop.
- CLK_DIV=1: ce_pix is continuously high in RUN.
- running=1 exactly in RUN.

## Timing
- Reset values: ce_pix=0, hcount=0, vcount=0, HBlank=1, VBlank=1, HSync=!HS_POL, VSync=!VS_POL, line_start=0, frame_start=0, running=0.
- All outputs are registered; there is no combinational input-to-output path.
- Start latency: enable high in cycle N (IDLE) gives running=1 in cycle N+1, and the first ce_pix with pixel (0,0) in cycle N+CLK_DIV.
- ce_pix period is exactly CLK_DIV clk. A line is H_TOTAL·CLK_DIV clk and a frame is H_TOTAL·V_TOTAL·CLK_DIV clk (419 200 at defaults).
- Reset asserted mid-operation forces the reset values immediately, independent of clk. After release the block is in IDLE and restarts only via enable.

## Test plan
- Reset, then hold enable=0 for 100 clk -> all outputs at reset values; ce_pix never pulses.
- enable=1 at cycle N -> running=1 at N+1; first ce_pix at N+4 with hcount=0, vcount=0, frame_start=1, line_start=1, HBlank=0. Subsequent ce_pix every 4 clk.
- Run one line -> HBlank rises at hcount=320. HSync goes low at 336 and high at 368. line_start fires again 1600 clk after the previous one.
- Run a full frame -> VBlank rises at vcount=240 and VSync is low for vcount 244..246. frame_start recurs every 419 200 clk. vcount never exceeds 261.
- Drop enable at vcount=100 -> counting continues to (399,261). The next wrap issues no ce_pix and running=0; a re-enable afterwards restarts at (0,0).
- Assert reset at hcount=200 between clk edges -> outputs reach reset values before the next clk edge. With CLK_DIV=1, re-enable -> ce_pix is continuously high.

Source files
------------

// File: rtl/video_timing_if.sv
// rtl/video_timing_if.sv - run request and raster timing outputs of the video timing sequencer
interface video_timing_if;
    logic       enable;
    logic       ce_pix;
    logic [8:0] hcount;
    logic [8:0] vcount;
    logic       HBlank;
    logic       VBlank;
    logic       HSync;
    logic       VSync;
    logic       line_start;
    logic       frame_start;
    logic       running;

    // timing generator side
    modport master (
        input  enable,
        output ce_pix,
        output hcount,
        output vcount,
        output HBlank,
        output VBlank,
        output HSync,
        output VSync,
        output line_start,
        output frame_start,
        output running
    );

    // mixer / pixel source side
    modport slave (
        output enable,
        input  ce_pix,
        input  hcount,
        input  vcount,
        input  HBlank,
        input  VBlank,
        input  HSync,
        input  VSync,
        input  line_start,
        input  frame_start,
        input  running
    );
endinterface

// File: rtl/video_timing.sv
// rtl/video_timing.sv - pixel-clock divider and raster timing sequencer
module video_timing #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 320,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 32,
    parameter int H_BP     = 32,
    parameter int V_ACTIVE = 240,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 15,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    video_timing_if.master vif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [8:0] H_LAST        = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST        = 9'(V_TOTAL - 1);
    localparam logic [8:0] H_BLANK_START = 9'(H_ACTIVE);
    localparam logic [8:0] H_SYNC_START  = 9'(H_ACTIVE + H_FP);
    localparam logic [8:0] H_SYNC_END    = 9'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [8:0] V_BLANK_START = 9'(V_ACTIVE);
    localparam logic [8:0] V_SYNC_START  = 9'(V_ACTIVE + V_FP);
    localparam logic [8:0] V_SYNC_END    = 9'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic HS_IDLE = ~1'(HS_POL);
    localparam logic VS_IDLE = ~1'(VS_POL);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             armed_q, armed_d;
    logic             ce_q, ce_d;
    logic [8:0]       h_q, h_d;
    logic [8:0]       v_q, v_d;
    logic             hblank_q, hblank_d;
    logic             vblank_q, vblank_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             ls_q, ls_d;
    logic             fs_q, fs_d;
    logic             run_q, run_d;

    logic             advance;
    logic             tick;
    logic             at_origin;
    logic [8:0]       h_new;
    logic [8:0]       v_new;

    // Next-state, divider and next-pixel decode. The edge that leaves IDLE
    // already counts as the first divider step, so the first pixel lands
    // CLK_DIV cycles after enable is sampled (immediately for CLK_DIV=1).
    // armed_q marks that the next presented pixel is the frame origin.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        armed_d  = armed_q;
        ce_d     = 1'b0;
        h_d      = h_q;
        v_d      = v_q;
        hblank_d = hblank_q;
        vblank_d = vblank_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        ls_d     = ls_q;
        fs_d     = fs_q;
        run_d    = run_q;

        advance   = (state_q == RUN) || vif.enable;
        tick      = advance && (div_q == DIV_LAST);
        at_origin = armed_q || ((h_q == H_LAST) && (v_q == V_LAST));

        if (armed_q) begin
            h_new = 9'd0;
            v_new = 9'd0;
        end else if (h_q == H_LAST) begin
            h_new = 9'd0;
            v_new = (v_q == V_LAST) ? 9'd0 : v_q + 9'd1;
        end else begin
            h_new = h_q + 9'd1;
            v_new = v_q;
        end

        case (state_q)
            IDLE: begin
                if (vif.enable) begin
                    state_d = RUN;
                    run_d   = 1'b1;
                end
            end
            RUN: begin
                // a stop only takes effect on the wrap into a new frame
                if (tick && at_origin && !vif.enable) begin
                    state_d = IDLE;
                    run_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                run_d   = 1'b0;
            end
        endcase

        if (advance) begin
            if (!tick) begin
                div_d = div_q + DIV_W'(1);
            end else if (state_d == IDLE) begin
                div_d    = '0;
                armed_d  = 1'b1;
                h_d      = 9'd0;
                v_d      = 9'd0;
                hblank_d = 1'b1;
                vblank_d = 1'b1;
                hsync_d  = HS_IDLE;
                vsync_d  = VS_IDLE;
                ls_d     = 1'b0;
                fs_d     = 1'b0;
            end else begin
                div_d    = '0;
                armed_d  = 1'b0;
                ce_d     = 1'b1;
                h_d      = h_new;
                v_d      = v_new;
                hblank_d = (h_new >= H_BLANK_START);
                vblank_d = (v_new >= V_BLANK_START);
                hsync_d  = ((h_new >= H_SYNC_START) && (h_new < H_SYNC_END)) ? 1'(HS_POL) : HS_IDLE;
                vsync_d  = ((v_new >= V_SYNC_START) && (v_new < V_SYNC_END)) ? 1'(VS_POL) : VS_IDLE;
                ls_d     = (h_new == 9'd0);
                fs_d     = (h_new == 9'd0) && (v_new == 9'd0);
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Divider, counters and registered raster outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q    <= '0;
            armed_q  <= 1'b1;
            ce_q     <= 1'b0;
            h_q      <= 9'd0;
            v_q      <= 9'd0;
            hblank_q <= 1'b1;
            vblank_q <= 1'b1;
            hsync_q  <= HS_IDLE;
            vsync_q  <= VS_IDLE;
            ls_q     <= 1'b0;
            fs_q     <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            div_q    <= div_d;
            armed_q  <= armed_d;
            ce_q     <= ce_d;
            h_q      <= h_d;
            v_q      <= v_d;
            hblank_q <= hblank_d;
            vblank_q <= vblank_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            ls_q     <= ls_d;
            fs_q     <= fs_d;
            run_q    <= run_d;
        end
    end

    assign vif.ce_pix      = ce_q;
    assign vif.hcount      = h_q;
    assign vif.vcount      = v_q;
    assign vif.HBlank      = hblank_q;
    assign vif.VBlank      = vblank_q;
    assign vif.HSync       = hsync_q;
    assign vif.VSync       = vsync_q;
    assign vif.line_start  = ls_q;
    assign vif.frame_start = fs_q;
    assign vif.running     = run_q;

endmodule
